// File: rtl/axi_lite_pkg.sv
// Shared constants and types for the AXI4-Lite register slave.
package axi_lite_pkg;

    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_RESP = 1'b1;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    // Write address and data latched independently until both have arrived.
    typedef struct packed {
        logic [31:0]       addr;
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
    } wr_req_t;

endpackage

// File: rtl/axi_lite_s_if.sv
// AXI4-Lite channel bundle between a master and the register slave.
interface axi_lite_s_if;
    import axi_lite_pkg::*;

    logic [31:0]       s_axi_awaddr;
    logic [2:0]        s_axi_awprot;
    logic              s_axi_awvalid;
    logic              s_axi_awready;
    logic [DATA_W-1:0] s_axi_wdata;
    logic [STRB_W-1:0] s_axi_wstrb;
    logic              s_axi_wvalid;
    logic              s_axi_wready;
    logic [1:0]        s_axi_bresp;
    logic              s_axi_bvalid;
    logic              s_axi_bready;
    logic [31:0]       s_axi_araddr;
    logic [2:0]        s_axi_arprot;
    logic              s_axi_arvalid;
    logic              s_axi_arready;
    logic [DATA_W-1:0] s_axi_rdata;
    logic [1:0]        s_axi_rresp;
    logic              s_axi_rvalid;
    logic              s_axi_rready;

    modport slave (
        input  s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
        input  s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        input  s_axi_bready,
        input  s_axi_araddr, s_axi_arprot, s_axi_arvalid,
        input  s_axi_rready,
        output s_axi_awready, s_axi_wready,
        output s_axi_bresp, s_axi_bvalid,
        output s_axi_arready,
        output s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );

    modport master (
        output s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
        output s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        output s_axi_bready,
        output s_axi_araddr, s_axi_arprot, s_axi_arvalid,
        output s_axi_rready,
        input  s_axi_awready, s_axi_wready,
        input  s_axi_bresp, s_axi_bvalid,
        input  s_axi_arready,
        input  s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );

endinterface

// File: rtl/axi_lite_regfile.sv
// NREGS x 32-bit register bank: byte-strobed write port, combinational read.
module axi_lite_regfile
    import axi_lite_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int IDXW  = $clog2(NREGS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [IDXW-1:0]         widx,
    input  logic [DATA_W-1:0]       wdata,
    input  logic [STRB_W-1:0]       wstrb,
    input  logic [IDXW-1:0]         ridx,
    output logic [DATA_W-1:0]       rdata,
    output logic [NREGS*DATA_W-1:0] regs
);

    logic [NREGS-1:0][DATA_W-1:0] mem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem <= '0;
        end else if (we) begin
            for (int k = 0; k < STRB_W; k++)
                if (wstrb[k]) mem[widx][8*k +: 8] <= wdata[8*k +: 8];
        end
    end

    assign rdata = mem[ridx];
    assign regs  = mem;

endmodule

// File: rtl/axi_lite_s.sv
// AXI4-Lite slave over a register bank; independent write and read FSMs.
module axi_lite_s
    import axi_lite_pkg::*;
#(
    parameter  int NREGS = 8,
    localparam int IDXW  = $clog2(NREGS)
) (
    input  logic                    aclk,
    input  logic                    areset,
    axi_lite_s_if.slave             s_axi,
    output logic [NREGS*DATA_W-1:0] usr_regs,
    output logic                    usr_wpulse,
    output logic [IDXW-1:0]         usr_widx
);

    function automatic logic in_range(input logic [31:0] addr);
        return addr[31:IDXW+2] == '0;
    endfunction

    logic [0:0]        w_state, r_state;
    logic              aw_got, w_got;
    wr_req_t           w_req;
    logic              awready, wready, bvalid, arready, rvalid;
    logic [1:0]        bresp, rresp;
    logic [DATA_W-1:0] rdata, rf_rdata;
    logic              aw_hs, w_hs, ar_hs, commit, w_ok;
    logic [IDXW-1:0]   w_idx, r_idx;

    assign aw_hs  = s_axi.s_axi_awvalid & awready;
    assign w_hs   = s_axi.s_axi_wvalid & wready;
    assign ar_hs  = s_axi.s_axi_arvalid & arready;
    assign w_idx  = w_req.addr[IDXW+1:2];
    assign r_idx  = s_axi.s_axi_araddr[IDXW+1:2];
    assign w_ok   = in_range(w_req.addr);
    assign commit = (w_state == W_IDLE) & aw_got & w_got;

    axi_lite_regfile #(.NREGS(NREGS), .IDXW(IDXW)) u_regfile (
        .clk   (aclk),
        .rst   (areset),
        .we    (commit & w_ok),
        .widx  (w_idx),
        .wdata (w_req.data),
        .wstrb (w_req.strb),
        .ridx  (r_idx),
        .rdata (rf_rdata),
        .regs  (usr_regs)
    );

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_state    <= W_IDLE;
            aw_got     <= 1'b0;
            w_got      <= 1'b0;
            w_req      <= '0;
            awready    <= 1'b0;
            wready     <= 1'b0;
            bvalid     <= 1'b0;
            bresp      <= RESP_OKAY;
            usr_wpulse <= 1'b0;
            usr_widx   <= '0;
        end else begin
            usr_wpulse <= 1'b0;
            case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_got     <= 1'b1;
                        w_req.addr <= s_axi.s_axi_awaddr;
                    end
                    if (w_hs) begin
                        w_got      <= 1'b1;
                        w_req.data <= s_axi.s_axi_wdata;
                        w_req.strb <= s_axi.s_axi_wstrb;
                    end
                    // Readies are already low here: both flags are set.
                    if (commit) begin
                        bvalid     <= 1'b1;
                        bresp      <= w_ok ? RESP_OKAY : RESP_SLVERR;
                        usr_wpulse <= w_ok;
                        if (w_ok) usr_widx <= w_idx;
                        w_state    <= W_RESP;
                    end else begin
                        awready <= !(aw_got | aw_hs);
                        wready  <= !(w_got | w_hs);
                    end
                end
                W_RESP: begin
                    if (s_axi.s_axi_bready) begin
                        bvalid  <= 1'b0;
                        aw_got  <= 1'b0;
                        w_got   <= 1'b0;
                        awready <= 1'b1;
                        wready  <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // rdata samples the bank before a same-edge commit lands.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        rdata   <= in_range(s_axi.s_axi_araddr) ? rf_rdata : '0;
                        rresp   <= in_range(s_axi.s_axi_araddr) ? RESP_OKAY : RESP_SLVERR;
                        rvalid  <= 1'b1;
                        arready <= 1'b0;
                        r_state <= R_DATA;
                    end else begin
                        arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_axi.s_axi_rready) begin
                        rvalid  <= 1'b0;
                        arready <= 1'b1;
                        r_state <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign s_axi.s_axi_awready = awready;
    assign s_axi.s_axi_wready  = wready;
    assign s_axi.s_axi_bvalid  = bvalid;
    assign s_axi.s_axi_bresp   = bresp;
    assign s_axi.s_axi_arready = arready;
    assign s_axi.s_axi_rvalid  = rvalid;
    assign s_axi.s_axi_rdata   = rdata;
    assign s_axi.s_axi_rresp   = rresp;

    logic unused;
    assign unused = ^{s_axi.s_axi_awprot, s_axi.s_axi_arprot, w_req.addr[1:0],
                      s_axi.s_axi_araddr[1:0]};

endmodule

// File: tb/tb_axi_lite_s.sv
// Directed bench for axi_lite_s: write/read vector table plus timing corner sequences.
module tb_axi_lite_s;
    import axi_lite_pkg::*;

    localparam int NREGS = 8;

    logic                  aclk = 1'b0;
    logic                  areset = 1'b1;
    logic [NREGS*32-1:0]   usr_regs;
    logic                  usr_wpulse;
    logic [2:0]            usr_widx;

    always #5 aclk = ~aclk;

    axi_lite_s_if bus();

    axi_lite_s #(.NREGS(NREGS)) dut (
        .aclk       (aclk),
        .areset     (areset),
        .s_axi      (bus),
        .usr_regs   (usr_regs),
        .usr_wpulse (usr_wpulse),
        .usr_widx   (usr_widx)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  bresp;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        int          pulses;
        int          widx;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model [NREGS];
    vec_t        vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_regs(input string tag);
        for (int i = 0; i < NREGS; i++)
            chk($sformatf("%s reg%0d", tag, i), usr_regs[32*i +: 32], model[i]);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                      output logic [1:0] resp, output int pulses, output int widx);
        logic aw_hs, w_hs, b_hs, done;
        pulses = 0; widx = -1; resp = 2'b11; done = 1'b0;
        @(negedge aclk);
        bus.s_axi_awaddr = addr; bus.s_axi_awvalid = 1'b1;
        bus.s_axi_wdata = data; bus.s_axi_wstrb = strb; bus.s_axi_wvalid = 1'b1;
        bus.s_axi_bready = 1'b1;
        for (int c = 0; c < 40 && !done; c++) begin
            aw_hs = bus.s_axi_awvalid & bus.s_axi_awready;
            w_hs  = bus.s_axi_wvalid & bus.s_axi_wready;
            b_hs  = bus.s_axi_bvalid & bus.s_axi_bready;
            if (b_hs) resp = bus.s_axi_bresp;
            @(negedge aclk);
            if (aw_hs) bus.s_axi_awvalid = 1'b0;
            if (w_hs) bus.s_axi_wvalid = 1'b0;
            if (usr_wpulse) begin pulses++; widx = int'(usr_widx); end
            if (b_hs) done = 1'b1;
        end
        bus.s_axi_bready = 1'b0; bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
        if (!done) chk("write timeout", 32'd0, 32'd1);
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        logic ar_hs, r_hs, done;
        data = 32'hxxxxxxxx; resp = 2'b11; done = 1'b0;
        @(negedge aclk);
        bus.s_axi_araddr = addr; bus.s_axi_arvalid = 1'b1; bus.s_axi_rready = 1'b1;
        for (int c = 0; c < 40 && !done; c++) begin
            ar_hs = bus.s_axi_arvalid & bus.s_axi_arready;
            r_hs  = bus.s_axi_rvalid & bus.s_axi_rready;
            if (r_hs) begin data = bus.s_axi_rdata; resp = bus.s_axi_rresp; end
            @(negedge aclk);
            if (ar_hs) bus.s_axi_arvalid = 1'b0;
            if (r_hs) done = 1'b1;
        end
        bus.s_axi_rready = 1'b0; bus.s_axi_arvalid = 1'b0;
        if (!done) chk("read timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [1:0]  resp, rresp;
        logic [31:0] rdat;
        int          pulses, widx;

        vecs[0] = '{32'h04, 32'hDEADBEEF, 4'hF, RESP_OKAY,   32'hDEADBEEF, RESP_OKAY,   1, 1};
        vecs[1] = '{32'h1C, 32'h12345678, 4'hF, RESP_OKAY,   32'h12345678, RESP_OKAY,   1, 7};
        vecs[2] = '{32'h03, 32'hA5A5A5A5, 4'h3, RESP_OKAY,   32'h0000A5A5, RESP_OKAY,   1, 0};
        vecs[3] = '{32'h20, 32'hCAFEF00D, 4'hF, RESP_SLVERR, 32'h00000000, RESP_SLVERR, 0, 0};
        vecs[4] = '{32'h1C, 32'hFFFFFFFF, 4'h0, RESP_OKAY,   32'h12345678, RESP_OKAY,   1, 7};
        vecs[5] = '{32'hFFFFFFFC, 32'h0F0F0F0F, 4'hF, RESP_SLVERR, 32'h00000000, RESP_SLVERR, 0, 0};

        for (int i = 0; i < NREGS; i++) model[i] = 32'h0;
        bus.s_axi_awaddr = '0; bus.s_axi_awprot = '0; bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wdata = '0; bus.s_axi_wstrb = '0; bus.s_axi_wvalid = 1'b0;
        bus.s_axi_bready = 1'b0;
        bus.s_axi_araddr = '0; bus.s_axi_arprot = '0; bus.s_axi_arvalid = 1'b0;
        bus.s_axi_rready = 1'b0;

        // Reset state
        repeat (2) @(negedge aclk);
        chk("rst awready", 32'(bus.s_axi_awready), 32'd0);
        chk("rst wready", 32'(bus.s_axi_wready), 32'd0);
        chk("rst arready", 32'(bus.s_axi_arready), 32'd0);
        chk("rst bvalid", 32'(bus.s_axi_bvalid), 32'd0);
        chk("rst rvalid", 32'(bus.s_axi_rvalid), 32'd0);
        chk("rst bresp", 32'(bus.s_axi_bresp), 32'd0);
        chk("rst rresp", 32'(bus.s_axi_rresp), 32'd0);
        chk("rst rdata", bus.s_axi_rdata, 32'd0);
        chk("rst wpulse", 32'(usr_wpulse), 32'd0);
        chk("rst widx", 32'(usr_widx), 32'd0);
        chk_regs("rst");
        areset = 1'b0;
        @(negedge aclk);
        chk("post-rst awready", 32'(bus.s_axi_awready), 32'd1);
        chk("post-rst wready", 32'(bus.s_axi_wready), 32'd1);
        chk("post-rst arready", 32'(bus.s_axi_arready), 32'd1);

        // Vector table: write, then read back the same address
        for (int v = 0; v < 6; v++) begin
            wr(vecs[v].addr, vecs[v].data, vecs[v].strb, resp, pulses, widx);
            chk($sformatf("v%0d bresp", v), 32'(resp), 32'(vecs[v].bresp));
            chk($sformatf("v%0d pulses", v), pulses, vecs[v].pulses);
            if (vecs[v].pulses == 1) chk($sformatf("v%0d widx", v), widx, vecs[v].widx);
            if (vecs[v].bresp == RESP_OKAY) model[vecs[v].addr[4:2]] = vecs[v].rdata;
            rd(vecs[v].addr, rdat, rresp);
            chk($sformatf("v%0d rdata", v), rdat, vecs[v].rdata);
            chk($sformatf("v%0d rresp", v), 32'(rresp), 32'(vecs[v].rresp));
            chk_regs($sformatf("v%0d", v));
        end

        // W three cycles ahead of AW, partial strobe over all-ones
        wr(32'h08, 32'hFFFFFFFF, 4'hF, resp, pulses, widx);
        model[2] = 32'hFFFFFFFF;
        @(negedge aclk);
        bus.s_axi_wdata = 32'h11223344; bus.s_axi_wstrb = 4'b0101; bus.s_axi_wvalid = 1'b1;
        @(negedge aclk);
        bus.s_axi_wvalid = 1'b0;
        chk("early-w wready low", 32'(bus.s_axi_wready), 32'd0);
        repeat (2) @(negedge aclk);
        chk("early-w awready", 32'(bus.s_axi_awready), 32'd1);
        chk("early-w bvalid idle", 32'(bus.s_axi_bvalid), 32'd0);
        bus.s_axi_awaddr = 32'h08; bus.s_axi_awvalid = 1'b1;
        @(negedge aclk);
        bus.s_axi_awvalid = 1'b0;
        chk("early-w bvalid at aw edge", 32'(bus.s_axi_bvalid), 32'd0);
        @(negedge aclk);
        chk("early-w bvalid", 32'(bus.s_axi_bvalid), 32'd1);
        chk("early-w bresp", 32'(bus.s_axi_bresp), 32'(RESP_OKAY));
        chk("early-w wpulse", 32'(usr_wpulse), 32'd1);
        chk("early-w widx", 32'(usr_widx), 32'd2);
        model[2] = 32'hFF22FF44;
        chk_regs("early-w");
        bus.s_axi_bready = 1'b1;
        @(negedge aclk);
        bus.s_axi_bready = 1'b0;
        chk("early-w bvalid clr", 32'(bus.s_axi_bvalid), 32'd0);
        chk("early-w awready back", 32'(bus.s_axi_awready), 32'd1);

        // Backpressure on B and R, second AW/W/AR stalled meanwhile
        @(negedge aclk);
        bus.s_axi_awaddr = 32'h10; bus.s_axi_awvalid = 1'b1;
        bus.s_axi_wdata = 32'h0BADF00D; bus.s_axi_wstrb = 4'hF; bus.s_axi_wvalid = 1'b1;
        bus.s_axi_araddr = 32'h10; bus.s_axi_arvalid = 1'b1;
        @(negedge aclk);
        bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0; bus.s_axi_arvalid = 1'b0;
        chk("bp rvalid", 32'(bus.s_axi_rvalid), 32'd1);
        chk("bp rdata old", bus.s_axi_rdata, 32'h0);
        @(negedge aclk);
        chk("bp bvalid", 32'(bus.s_axi_bvalid), 32'd1);
        model[4] = 32'h0BADF00D;
        bus.s_axi_awaddr = 32'h14; bus.s_axi_awvalid = 1'b1;
        bus.s_axi_wdata = 32'h01020304; bus.s_axi_wvalid = 1'b1;
        bus.s_axi_araddr = 32'h14; bus.s_axi_arvalid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge aclk);
            chk($sformatf("bp%0d bvalid", c), 32'(bus.s_axi_bvalid), 32'd1);
            chk($sformatf("bp%0d bresp", c), 32'(bus.s_axi_bresp), 32'(RESP_OKAY));
            chk($sformatf("bp%0d rvalid", c), 32'(bus.s_axi_rvalid), 32'd1);
            chk($sformatf("bp%0d rdata", c), bus.s_axi_rdata, 32'h0);
            chk($sformatf("bp%0d rresp", c), 32'(bus.s_axi_rresp), 32'(RESP_OKAY));
            chk($sformatf("bp%0d awready", c), 32'(bus.s_axi_awready), 32'd0);
            chk($sformatf("bp%0d wready", c), 32'(bus.s_axi_wready), 32'd0);
            chk($sformatf("bp%0d arready", c), 32'(bus.s_axi_arready), 32'd0);
        end
        chk_regs("bp hold");
        bus.s_axi_bready = 1'b1; bus.s_axi_rready = 1'b1;
        @(negedge aclk);
        chk("bp bvalid clr", 32'(bus.s_axi_bvalid), 32'd0);
        chk("bp rvalid clr", 32'(bus.s_axi_rvalid), 32'd0);
        chk("bp awready back", 32'(bus.s_axi_awready), 32'd1);
        chk("bp wready back", 32'(bus.s_axi_wready), 32'd1);
        chk("bp arready back", 32'(bus.s_axi_arready), 32'd1);
        @(negedge aclk);
        bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0; bus.s_axi_arvalid = 1'b0;
        chk("bp2 rvalid", 32'(bus.s_axi_rvalid), 32'd1);
        chk("bp2 rdata old", bus.s_axi_rdata, 32'h0);
        @(negedge aclk);
        chk("bp2 bvalid", 32'(bus.s_axi_bvalid), 32'd1);
        chk("bp2 wpulse", 32'(usr_wpulse), 32'd1);
        chk("bp2 widx", 32'(usr_widx), 32'd5);
        model[5] = 32'h01020304;
        chk_regs("bp2");
        @(negedge aclk);
        chk("bp2 bvalid clr", 32'(bus.s_axi_bvalid), 32'd0);
        bus.s_axi_bready = 1'b0; bus.s_axi_rready = 1'b0;

        // AR capture on the same edge as a commit to that register
        wr(32'h0C, 32'hAAAAAAAA, 4'hF, resp, pulses, widx);
        model[3] = 32'hAAAAAAAA;
        @(negedge aclk);
        bus.s_axi_awaddr = 32'h0C; bus.s_axi_awvalid = 1'b1;
        bus.s_axi_wdata = 32'h55555555; bus.s_axi_wstrb = 4'hF; bus.s_axi_wvalid = 1'b1;
        bus.s_axi_bready = 1'b1;
        @(negedge aclk);
        bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
        bus.s_axi_araddr = 32'h0C; bus.s_axi_arvalid = 1'b1;
        @(negedge aclk);
        bus.s_axi_arvalid = 1'b0;
        chk("raw rvalid", 32'(bus.s_axi_rvalid), 32'd1);
        chk("raw rdata pre-write", bus.s_axi_rdata, 32'hAAAAAAAA);
        chk("raw bvalid", 32'(bus.s_axi_bvalid), 32'd1);
        model[3] = 32'h55555555;
        chk_regs("raw");
        bus.s_axi_rready = 1'b1;
        @(negedge aclk);
        bus.s_axi_rready = 1'b0; bus.s_axi_bready = 1'b0;
        rd(32'h0C, rdat, rresp);
        chk("raw reread", rdat, 32'h55555555);

        // Reset while a response is pending
        @(negedge aclk);
        bus.s_axi_awaddr = 32'h18; bus.s_axi_awvalid = 1'b1;
        bus.s_axi_wdata = 32'h00000077; bus.s_axi_wvalid = 1'b1;
        @(negedge aclk);
        bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
        @(negedge aclk);
        chk("mid-rst bvalid before", 32'(bus.s_axi_bvalid), 32'd1);
        #2 areset = 1'b1;
        #1;
        chk("mid-rst bvalid", 32'(bus.s_axi_bvalid), 32'd0);
        chk("mid-rst awready", 32'(bus.s_axi_awready), 32'd0);
        for (int i = 0; i < NREGS; i++) model[i] = 32'h0;
        chk_regs("mid-rst");
        repeat (2) @(negedge aclk);
        areset = 1'b0;
        bus.s_axi_bready = 1'b1;
        @(negedge aclk);
        chk("rel awready", 32'(bus.s_axi_awready), 32'd1);
        chk("rel wready", 32'(bus.s_axi_wready), 32'd1);
        chk("rel arready", 32'(bus.s_axi_arready), 32'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge aclk);
            chk($sformatf("rel%0d bvalid", c), 32'(bus.s_axi_bvalid), 32'd0);
        end
        bus.s_axi_bready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
